// File: rtl/dcnn_io_pkg.sv
// Constants and state encoding shared by the DCNN coordinator and its
// image-load path.
package dcnn_io_pkg;

  localparam int          DEF_IMAGE_PIXELS = 784;
  localparam logic [15:0] DEF_PIXEL_ONE    = 16'h0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } decomp_state_e;

endpackage

// File: rtl/image_decompressor.sv
// Run-length expander: turns compressed {value, run} words into consecutive
// pixel writes into the shared parameter/image RAM.
module image_decompressor
  import dcnn_io_pkg::*;
#(
  parameter int                IMAGE_PIXELS = DEF_IMAGE_PIXELS,
  parameter int                DATA_W       = 16,
  parameter int                ADDR_W       = 16,
  parameter int                RUN_W        = 6,
  parameter logic [DATA_W-1:0] PIXEL_ONE    = DEF_PIXEL_ONE
) (
  input  logic                                  clk,
  input  logic                                  RST,
  input  logic                                  load,
  input  logic                                  cnn,
  input  logic [15:0]                           Din,
  input  logic                                  dinValid,
  input  logic [ADDR_W-1:0]                     imageBaseAddr,
  output logic                                  ready,
  output logic [ADDR_W-1:0]                     ramAddress,
  output logic [DATA_W-1:0]                     ramDataIn,
  output logic                                  writeSignal,
  output logic [$clog2(IMAGE_PIXELS+1)-1:0]     pixelCount,
  output logic                                  imageDone,
  output logic                                  overflow
);

  localparam int             CNT_W   = $clog2(IMAGE_PIXELS + 1);
  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(32);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMAGE_PIXELS);

  decomp_state_e     r_state;
  logic [RUN_W-1:0]  r_rem;
  logic              r_value;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_count;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_ovf;

  logic              w_act;
  logic [RUN_W-1:0]  w_run_raw;
  logic [RUN_W-1:0]  w_run;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused_bits;

  assign w_act         = load & ~cnn;
  assign w_run_raw     = Din[RUN_W-1:0];
  assign w_run         = (w_run_raw > MAX_RUN) ? MAX_RUN : w_run_raw;
  assign w_unused_bits = ^Din[14:RUN_W];

  // The first word of an image uses the live base; later words reuse the latched one.
  assign w_base = (r_count == '0) ? imageBaseAddr : r_base;
  assign w_addr = w_base + ADDR_W'(r_count);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_value <= 1'b0;
      r_base  <= '0;
      r_count <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_act && dinValid) begin
            if (r_count == '0) r_base <= imageBaseAddr;
            r_value <= Din[15];
            if (w_run != '0) begin
              // The first pixel is issued on the accept edge so it is visible next cycle.
              r_state <= EMIT;
              r_rem   <= w_run;
              r_write <= 1'b1;
              r_addr  <= w_addr;
              r_data  <= Din[15] ? PIXEL_ONE : '0;
              r_count <= r_count + 1'b1;
            end
          end
        end
        EMIT: begin
          if (!w_act) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (r_count == LAST_CNT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (r_rem > RUN_W'(1)) r_ovf <= 1'b1;
          end else if (r_rem == RUN_W'(1)) begin
            r_state <= IDLE;
          end else begin
            r_rem   <= r_rem - 1'b1;
            r_write <= 1'b1;
            r_addr  <= w_addr;
            r_data  <= r_value ? PIXEL_ONE : '0;
            r_count <= r_count + 1'b1;
          end
        end
        DONE: begin
          if (!w_act) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready       = w_act && (r_state == IDLE);
  assign ramAddress  = r_addr;
  assign ramDataIn   = r_data;
  assign writeSignal = r_write;
  assign pixelCount  = r_count;
  assign imageDone   = r_done;
  assign overflow    = r_ovf;

endmodule
